// File: rtl/ls_mem_arbiter_pkg.sv
// rtl/ls_mem_arbiter_pkg.sv - shared types for the load/store memory-bus arbiter
package ls_mem_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int LSQ_IDX_LEN = 3;
  localparam int MEM_TAG_W   = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_LD = 2'd1,
    ISSUE_ST = 2'd2,
    WAIT_LD  = 2'd3
  } ls_arb_state_e;

  typedef enum logic {
    GRANT_LOAD  = 1'b0,
    GRANT_STORE = 1'b1
  } grant_e;

  typedef struct packed {
    logic [XLEN-1:0]        addr;
    mem_size_e              size;
    logic                   is_unsigned;
    logic [LSQ_IDX_LEN-1:0] lq_pos;
  } ld_req_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    mem_size_e       size;
  } st_req_t;

  typedef struct packed {
    logic [XLEN-1:0]        value;
    logic [LSQ_IDX_LEN-1:0] lq_pos;
  } ld_resp_t;

endpackage

// File: rtl/ls_mem_arbiter_ld_data_extract.sv
// rtl/ls_mem_arbiter_ld_data_extract.sv - byte/half/word select and extend from a doubleword
module ld_data_extract #(
  parameter int XLEN = 32
) (
  input  logic [63:0]     data,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value
);
  import ls_mem_arbiter_pkg::*;

  logic [31:0] shifted;

  always_comb begin
    shifted = 32'(data >> {offset, 3'b000});
    case (size)
      MEM_BYTE: value = is_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      MEM_HALF: value = is_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      default:  value = is_unsigned ? XLEN'(shifted)       : XLEN'($signed(shifted));
    endcase
  end

endmodule

// File: rtl/ls_mem_arbiter.sv
// rtl/ls_mem_arbiter.sv - arbitrates loads and committed stores onto the single data-memory bus
module ls_mem_arbiter #(
  parameter int XLEN        = ls_mem_arbiter_pkg::XLEN,
  parameter int LSQ_IDX_LEN = ls_mem_arbiter_pkg::LSQ_IDX_LEN,
  parameter int MEM_TAG_W   = ls_mem_arbiter_pkg::MEM_TAG_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   squash,
  input  logic                   ld_req_valid,
  input  logic [XLEN-1:0]        ld_req_addr,
  input  logic [1:0]             ld_req_size,
  input  logic                   ld_req_unsigned,
  input  logic [LSQ_IDX_LEN-1:0] ld_req_lq_pos,
  output logic                   ld_req_ready,
  input  logic                   st_req_valid,
  input  logic [XLEN-1:0]        st_req_addr,
  input  logic [XLEN-1:0]        st_req_data,
  input  logic [1:0]             st_req_size,
  input  logic                   st_req_urgent,
  output logic                   st_req_ready,
  output logic [1:0]             proc2mem_command,
  output logic [XLEN-1:0]        proc2mem_addr,
  output logic [63:0]            proc2mem_data,
  output logic [1:0]             proc2mem_size,
  input  logic [MEM_TAG_W-1:0]   mem2proc_response,
  input  logic [63:0]            mem2proc_data,
  input  logic [MEM_TAG_W-1:0]   mem2proc_tag,
  output logic                   ld_resp_valid,
  output logic [XLEN-1:0]        ld_resp_value,
  output logic [LSQ_IDX_LEN-1:0] ld_resp_lq_pos
);
  import ls_mem_arbiter_pkg::*;

  ls_arb_state_e          state_q, state_d;
  grant_e                 last_grant_q, last_grant_d;
  logic [XLEN-1:0]        addr_q, addr_d, data_q, data_d;
  logic [1:0]             size_q, size_d;
  logic                   unsigned_q, unsigned_d;
  logic [LSQ_IDX_LEN-1:0] lq_pos_q, lq_pos_d;
  logic [MEM_TAG_W-1:0]   saved_tag_q, saved_tag_d;
  logic                   drop_q, drop_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]        resp_value_q, resp_value_d;
  logic [LSQ_IDX_LEN-1:0] resp_lq_pos_q, resp_lq_pos_d;

  logic            idle, ld_ok, grant_ld, grant_st, tag_hit;
  logic [XLEN-1:0] extracted;

  ld_data_extract #(.XLEN(XLEN)) u_extract (
    .data        (mem2proc_data),
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .value       (extracted)
  );

  // A squashed load is never accepted, so a waiting store wins the cycle instead.
  assign idle     = (state_q == IDLE);
  assign ld_ok    = ld_req_valid && !squash;
  assign grant_st = idle && st_req_valid && (!ld_ok || st_req_urgent || last_grant_q == GRANT_LOAD);
  assign grant_ld = idle && ld_ok && !grant_st;
  assign tag_hit  = (state_q == WAIT_LD) && (saved_tag_q != '0) && (mem2proc_tag == saved_tag_q);

  assign ld_req_ready   = grant_ld;
  assign st_req_ready   = grant_st;
  assign ld_resp_valid  = resp_valid_q;
  assign ld_resp_value  = resp_value_q;
  assign ld_resp_lq_pos = resp_lq_pos_q;

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    proc2mem_size    = '0;
    if (state_q == ISSUE_LD) begin
      proc2mem_command = BUS_LOAD;
      proc2mem_addr    = addr_q;
      proc2mem_size    = size_q;
    end else if (state_q == ISSUE_ST) begin
      proc2mem_command = BUS_STORE;
      proc2mem_addr    = addr_q;
      proc2mem_data    = {{(64-XLEN){1'b0}}, data_q};
      proc2mem_size    = size_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    data_d        = data_q;
    size_d        = size_q;
    unsigned_d    = unsigned_q;
    lq_pos_d      = lq_pos_q;
    saved_tag_d   = saved_tag_q;
    drop_d        = drop_q;
    resp_valid_d  = 1'b0;
    resp_value_d  = resp_value_q;
    resp_lq_pos_d = resp_lq_pos_q;
    case (state_q)
      IDLE: begin
        if (grant_ld) begin
          state_d      = ISSUE_LD;
          last_grant_d = GRANT_LOAD;
          addr_d       = ld_req_addr;
          data_d       = '0;
          size_d       = ld_req_size;
          unsigned_d   = ld_req_unsigned;
          lq_pos_d     = ld_req_lq_pos;
        end else if (grant_st) begin
          state_d      = ISSUE_ST;
          last_grant_d = GRANT_STORE;
          addr_d       = st_req_addr;
          data_d       = st_req_data;
          size_d       = st_req_size;
        end
      end
      // An accepted load must still be tracked to completion even if squashed now.
      ISSUE_LD: begin
        if (mem2proc_response != '0) begin
          saved_tag_d = mem2proc_response;
          drop_d      = squash;
          state_d     = WAIT_LD;
        end else if (squash) begin
          state_d = IDLE;
        end
      end
      ISSUE_ST: begin
        if (mem2proc_response != '0) state_d = IDLE;
      end
      WAIT_LD: begin
        if (squash) drop_d = 1'b1;
        if (tag_hit) begin
          if (!(drop_q || squash)) begin
            resp_valid_d  = 1'b1;
            resp_value_d  = extracted;
            resp_lq_pos_d = lq_pos_q;
          end
          saved_tag_d = '0;
          drop_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= GRANT_STORE;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      lq_pos_q      <= '0;
      saved_tag_q   <= '0;
      drop_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_value_q  <= '0;
      resp_lq_pos_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      size_q        <= size_d;
      unsigned_q    <= unsigned_d;
      lq_pos_q      <= lq_pos_d;
      saved_tag_q   <= saved_tag_d;
      drop_q        <= drop_d;
      resp_valid_q  <= resp_valid_d;
      resp_value_q  <= resp_value_d;
      resp_lq_pos_q <= resp_lq_pos_d;
    end
  end

endmodule

// File: tb/tb_ls_mem_arbiter.sv
// tb/tb_ls_mem_arbiter.sv - scoreboard bench for ls_mem_arbiter with a behavioural memory
module tb_ls_mem_arbiter;

  localparam int LAT = 3;

  logic        clock, reset, squash;
  logic        ld_req_valid, ld_req_unsigned, ld_req_ready;
  logic [31:0] ld_req_addr;
  logic [1:0]  ld_req_size;
  logic [2:0]  ld_req_lq_pos;
  logic        st_req_valid, st_req_urgent, st_req_ready;
  logic [31:0] st_req_addr, st_req_data;
  logic [1:0]  st_req_size;
  logic [1:0]  proc2mem_command, proc2mem_size;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [63:0] mem2proc_data;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_value;
  logic [2:0]  ld_resp_lq_pos;

  ls_mem_arbiter dut (
    .clock(clock), .reset(reset), .squash(squash),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_size(ld_req_size),
    .ld_req_unsigned(ld_req_unsigned), .ld_req_lq_pos(ld_req_lq_pos), .ld_req_ready(ld_req_ready),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_size(st_req_size), .st_req_urgent(st_req_urgent), .st_req_ready(st_req_ready),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_value(ld_resp_value), .ld_resp_lq_pos(ld_resp_lq_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct { logic [31:0] value; logic [2:0] pos; } resp_t;
  typedef struct { logic [1:0] cmd; logic [31:0] addr; logic [63:0] data; logic [1:0] size; } bus_t;

  resp_t       exp_q[$];
  bus_t        acc_q[$];
  int          cyc = 0, tag_cyc = -10, rej_left = 0, pend_cnt = -1;
  int          issue_cnt = 0, hold_diffs = 0, resp_seen = 0;
  logic [3:0]  next_tag = 4'd1, pend_tag = 4'd0;
  logic [63:0] mem_rdata = '0;

  // Behavioural memory: rejects rej_left issue cycles, then accepts with next_tag.
  initial begin
    logic [97:0] cur_v, prev_v;
    bit          prev_issue;
    bus_t        b;
    prev_issue = 0;
    prev_v = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      mem2proc_tag = '0; mem2proc_data = '0; mem2proc_response = '0;
      if (pend_cnt > 0) pend_cnt--;
      if (pend_cnt == 0) begin
        mem2proc_tag = pend_tag; mem2proc_data = mem_rdata; tag_cyc = cyc; pend_cnt = -1;
      end
      if (proc2mem_command != 2'd0) begin
        issue_cnt++;
        cur_v = {proc2mem_command, proc2mem_addr, proc2mem_data};
        if (prev_issue && cur_v != prev_v) hold_diffs++;
        prev_issue = 1; prev_v = cur_v;
        if (rej_left > 0) rej_left--;
        else begin
          mem2proc_response = next_tag;
          b.cmd = proc2mem_command; b.addr = proc2mem_addr; b.data = proc2mem_data; b.size = proc2mem_size;
          acc_q.push_back(b);
          if (proc2mem_command == 2'd1) begin pend_tag = next_tag; pend_cnt = LAT; end
          next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
          prev_issue = 0;
        end
      end else prev_issue = 0;
    end
  end

  always @(negedge clock) begin
    if (ld_resp_valid) begin
      resp_t r;
      resp_seen++;
      if (exp_q.size() == 0) check_eq("unexpected_resp", 1, 0);
      else begin
        r = exp_q.pop_front();
        check_eq("resp_value", ld_resp_value, r.value);
        check_eq("resp_lq_pos", ld_resp_lq_pos, r.pos);
        check_eq("resp_latency", cyc - tag_cyc, 1);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic issue_ld(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [2:0] pos, input logic [31:0] expv, input bit want);
    bit got = 0;
    resp_t r;
    @(posedge clock); #2;
    ld_req_valid = 1; ld_req_addr = a; ld_req_size = sz; ld_req_unsigned = u; ld_req_lq_pos = pos;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (ld_req_ready) got = 1;
      @(posedge clock); #2;
    end
    ld_req_valid = 0;
    check_eq("ld_handshake", got, 1);
    if (got && want) begin r.value = expv; r.pos = pos; exp_q.push_back(r); end
  endtask

  task automatic issue_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    bit got = 0;
    @(posedge clock); #2;
    st_req_valid = 1; st_req_addr = a; st_req_data = d; st_req_size = sz;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (st_req_ready) got = 1;
      @(posedge clock); #2;
    end
    st_req_valid = 0;
    check_eq("st_handshake", got, 1);
  endtask

  task automatic wait_acc();
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) begin
      @(posedge clock); #2;
    end
    check_eq("mem_accept_seen", acc_q.size() > 0, 1);
  endtask

  task automatic contend(input bit urgent, input string name);
    int    nl = 4, ns = 4, g;
    bit    order[$];
    resp_t r;
    bus_t  b;
    @(posedge clock); #2;
    st_req_urgent = urgent;
    ld_req_addr = 32'h204; ld_req_size = 2; ld_req_unsigned = 0; ld_req_lq_pos = 0;
    st_req_addr = 32'h500; st_req_data = 32'h1; st_req_size = 2;
    ld_req_valid = 1; st_req_valid = 1;
    for (int c = 0; c < 400 && (nl > 0 || ns > 0); c++) begin
      @(negedge clock);
      if (ld_req_ready && st_req_ready) check_eq({name, "_ready_excl"}, 1, 0);
      g = ld_req_ready ? 0 : (st_req_ready ? 1 : 2);
      @(posedge clock); #2;
      if (g == 0) begin
        r.value = 32'h11112222; r.pos = ld_req_lq_pos; exp_q.push_back(r);
        order.push_back(0); nl--;
        if (nl == 0) ld_req_valid = 0;
        else begin ld_req_addr += 8; ld_req_lq_pos++; end
      end else if (g == 1) begin
        order.push_back(1); ns--;
        if (ns == 0) st_req_valid = 0;
        else begin st_req_addr += 8; st_req_data++; end
      end
    end
    ld_req_valid = 0; st_req_valid = 0; st_req_urgent = 0;
    wait_cycles(10);
    check_eq({name, "_grant_count"}, order.size(), 8);
    check_eq({name, "_bus_count"}, acc_q.size(), 8);
    for (int i = 0; i < 8 && i < order.size(); i++) begin
      bit exp_st = urgent ? (i < 4) : (i % 2 == 1);
      check_eq($sformatf("%s_grant%0d", name, i), order[i], exp_st);
      if (acc_q.size() > 0) begin
        b = acc_q.pop_front();
        check_eq($sformatf("%s_buscmd%0d", name, i), b.cmd, exp_st ? 2'd2 : 2'd1);
      end
    end
    acc_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus_t b;
    int   seen0;
    reset = 1; squash = 0;
    ld_req_valid = 0; ld_req_addr = '0; ld_req_size = '0; ld_req_unsigned = 0; ld_req_lq_pos = '0;
    st_req_valid = 0; st_req_addr = '0; st_req_data = '0; st_req_size = '0; st_req_urgent = 0;
    repeat (3) @(posedge clock);
    #2 reset = 0;
    @(negedge clock);
    check_eq("rst_command", proc2mem_command, 0);
    check_eq("rst_addr", proc2mem_addr, 0);
    check_eq("rst_resp_valid", ld_resp_valid, 0);
    check_eq("rst_resp_value", ld_resp_value, 0);
    check_eq("rst_resp_pos", ld_resp_lq_pos, 0);
    check_eq("rst_ready", {ld_req_ready, st_req_ready}, 0);

    // Word load at upper half of the doubleword
    mem_rdata = 64'h89ABCDEF_01234567; next_tag = 4'd3;
    issue_ld(32'h104, 2'd2, 1'b0, 3'd5, 32'h89ABCDEF, 1);
    wait_acc();
    if (acc_q.size() > 0) begin
      b = acc_q.pop_front();
      check_eq("t1_bus_cmd", b.cmd, 1);
      check_eq("t1_bus_addr", b.addr, 32'h104);
      check_eq("t1_bus_size", b.size, 2);
    end
    wait_cycles(8);

    // Byte and half extension
    mem_rdata = 64'h80000000_00000000;
    issue_ld(32'h107, 2'd0, 1'b0, 3'd1, 32'hFFFFFF80, 1); wait_cycles(8);
    issue_ld(32'h107, 2'd0, 1'b1, 3'd2, 32'h00000080, 1); wait_cycles(8);
    mem_rdata = 64'h00000000_BEEF0000;
    issue_ld(32'h10A, 2'd1, 1'b0, 3'd3, 32'hFFFFBEEF, 1); wait_cycles(8);
    check_eq("t2_all_returned", exp_q.size(), 0);

    // Contention, fair then urgent
    reset = 1; wait_cycles(2); reset = 0;
    acc_q.delete();
    mem_rdata = 64'h11112222_33334444;
    contend(1'b0, "fair");
    contend(1'b1, "urgent");
    check_eq("t3_all_returned", exp_q.size(), 0);

    // Rejections: identical command held 4 cycles, tag 5
    issue_cnt = 0; hold_diffs = 0; rej_left = 3; next_tag = 4'd5;
    mem_rdata = 64'h00000000_CAFEF00D;
    issue_ld(32'h300, 2'd2, 1'b1, 3'd6, 32'hCAFEF00D, 1);
    wait_cycles(10);
    check_eq("t4_issue_cycles", issue_cnt, 4);
    check_eq("t4_hold_diffs", hold_diffs, 0);
    check_eq("t4_accepts", acc_q.size(), 1);
    check_eq("t4_returned", exp_q.size(), 0);
    acc_q.delete();

    // Squash in WAIT_LD drops the result; the next load is served
    seen0 = resp_seen;
    issue_ld(32'h108, 2'd2, 1'b0, 3'd7, 32'h0, 0);
    wait_acc();
    @(posedge clock); #2 squash = 1;
    @(posedge clock); #2 squash = 0;
    wait_cycles(8);
    check_eq("t5_dropped", resp_seen - seen0, 0);
    mem_rdata = 64'h0BADF00D_00000000;
    issue_ld(32'h110 + 32'h4, 2'd2, 1'b1, 3'd2, 32'h0BADF00D, 1);
    wait_cycles(8);
    check_eq("t5_next_served", resp_seen - seen0, 1);
    acc_q.delete();

    // Squash during a rejected store does not kill it
    rej_left = 2;
    issue_st(32'h400, 32'hDEADBEEF, 2'd2);
    squash = 1; wait_cycles(3); squash = 0;
    wait_cycles(5);
    check_eq("t6_accepts", acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      b = acc_q.pop_front();
      check_eq("t6_cmd", b.cmd, 2);
      check_eq("t6_addr", b.addr, 32'h400);
      check_eq("t6_data", b.data, 64'h00000000_DEADBEEF);
      check_eq("t6_size", b.size, 2);
    end

    // Reset in WAIT_LD; the late tag must be ignored
    seen0 = resp_seen;
    issue_ld(32'h120, 2'd2, 1'b0, 3'd4, 32'h0, 0);
    wait_acc();
    @(posedge clock); #2 reset = 1;
    @(posedge clock); #2 reset = 0;
    wait_cycles(6);
    @(negedge clock);
    check_eq("t7_no_resp", resp_seen - seen0, 0);
    check_eq("t7_command", proc2mem_command, 0);
    check_eq("t7_resp_value", ld_resp_value, 0);
    check_eq("t7_resp_pos", ld_resp_lq_pos, 0);
    check_eq("t7_resp_valid", ld_resp_valid, 0);
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ls_mem_arbiter.md
Name: ls_mem_arbiter

Overview:
- Sequences the single data-memory bus between two requesters: speculative loads coming out of the load/store FU path, and committed stores draining from the store queue.
- Grants one requester at a time and retries bus rejections.
- Tracks the tagged memory response for the one outstanding load, extracts and extends the loaded value, and returns it with its load-queue position.
- Drops in-flight load results on squash. Sits between the LSQ/fu_ls and the processor memory interface.

Parameters:
- XLEN, 32, architectural data width
- LSQ_IDX_LEN, 3, load-queue position width
- MEM_TAG_W, 4, memory response/tag width; tag 0 means "no response / rejected"

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- squash  in  1  pipeline flush; kills pending and in-flight loads only
- ld_req_valid  in  1  load request present
- ld_req_addr  in  XLEN  byte address
- ld_req_size  in  2  MEM_SIZE: 0 byte, 1 half, 2 word
- ld_req_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- ld_req_lq_pos  in  LSQ_IDX_LEN  load-queue slot
- ld_req_ready  out  1  load accepted this cycle when high with valid
- st_req_valid  in  1  committed store present
- st_req_addr  in  XLEN  byte address
- st_req_data  in  XLEN  store data, right-aligned
- st_req_size  in  2  MEM_SIZE
- st_req_urgent  in  1  store queue full; forces store priority
- st_req_ready  out  1  store accepted this cycle when high with valid
- proc2mem_command  out  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- proc2mem_addr  out  XLEN  bus address
- proc2mem_data  out  64  {32'b0, store data}
- proc2mem_size  out  2  bus access size
- mem2proc_response  in  MEM_TAG_W  0 = rejected, else the transaction tag
- mem2proc_data  in  64  doubleword containing the load address
- mem2proc_tag  in  MEM_TAG_W  tag of the returning data
- ld_resp_valid  out  1  one-cycle pulse, load data ready
- ld_resp_value  out  XLEN  extended load value
- ld_resp_lq_pos  out  LSQ_IDX_LEN  slot of the returned load

Behaviour:
- Reset/clock: reset is synchronous, active-high; all logic is clocked on clock.
- FSM states: IDLE, ISSUE_LD, ISSUE_ST, WAIT_LD. Reset → IDLE.
- Reset values: saved_tag = 0, drop = 0, last_grant = STORE (so the first tie grants the load), ld_resp_valid = 0, ld_resp_value = 0, ld_resp_lq_pos = 0. Bus outputs are 0 (BUS_NONE) whenever the FSM is not in ISSUE_*.
- Ready signals: ld_req_ready and st_req_ready are combinational. High only in IDLE and never both in one cycle. ld_req_ready is forced low while squash is high.
- Arbitration in IDLE:
  - Only one requester valid → grant it.
  - Both valid and st_req_urgent → store.
  - Both valid otherwise → the requester opposite last_grant.
  - last_grant updates on each grant.
  - The accepted request is latched into holding registers; the next state is ISSUE_LD or ISSUE_ST.
- ISSUE_*: drive the command, addr, size and data from the holding registers.
  - mem2proc_response == 0 → stay and reissue the identical command next cycle.
  - Nonzero response on a store → IDLE; the store is complete (fire-and-forget).
  - Nonzero response on a load → saved_tag = response, go to WAIT_LD.
- WAIT_LD: bus idle. When mem2proc_tag == saved_tag and saved_tag != 0:
  - Select the byte/half/word at offset addr[2:0] of mem2proc_data.
  - Sign- or zero-extend per the unsigned bit.
  - Register the result: ld_resp_valid pulses the following cycle with the value and lq_pos, unless drop is set.
  - Clear saved_tag and drop; go to IDLE.
- Latency: unloaded load = accept (cycle 0), issue (cycle 1, if accepted), data at memory latency, ld_resp_valid one cycle after the tag match.
- Alignment: requests are naturally aligned by contract; there is no misalignment handling. Half-word selection uses addr[2:1], byte selection uses addr[2:0].
- Squash:
  - In ISSUE_LD → abandon without a completed handshake, go to IDLE. A same-cycle nonzero response is still treated as accepted: go to WAIT_LD with drop = 1.
  - In WAIT_LD → drop = 1; keep waiting for the tag so the response is not misattributed to a later load.
  - Squash does not affect ISSUE_ST or a pending store.
  - Squash in IDLE → no load accepted that cycle.
- Simultaneous events: a tag match and a squash in the same cycle → the response is dropped.
- Reset mid-operation: everything is cleared. A late tag from the old transaction never matches because saved_tag = 0.

Decomposition:
- Shared package: BUS_COMMAND enum, MEM_SIZE enum, MEM_TAG_W, LS_ARB_STATE enum, and the LD_REQ/ST_REQ/LD_RESP packet structs.
- One sub-module: ld_data_extract (combinational byte/half/word select and extension from 64-bit data by offset, size and unsigned bit), reused later by store-to-load forwarding.

Test Plan:
- Load only: addr 0x104, word, signed; response 3, then tag 3 with data 0x89ABCDEF_01234567 → ld_resp_value 0x89ABCDEF, pulse one cycle after the tag match, lq_pos echoed.
- Byte loads at addr 0x107: data byte 0x80, signed → 0xFFFFFF80; unsigned → 0x00000080.
- Contention: load and store valid together for 4 consecutive requests each, urgent = 0 → grants alternate L, S, L, S. With urgent = 1 → store granted every time.
- Rejection: response 0 for 3 cycles, then 5 → the identical command is held for 4 cycles, saved_tag = 5, no duplicate issue.
- Squash in WAIT_LD, then tag match → no ld_resp_valid, FSM returns to IDLE, next load is served normally. Squash during ISSUE_ST → store completes.
- Reset asserted in WAIT_LD, then old tag arrives → no response, FSM in IDLE, all outputs 0.
